// File: rtl/ic_id_inst_queue.sv
// ============================================================================
//  Module   : ic_id_inst_queue
//  Purpose  : Instruction queue and ID-stage output register between the
//             I-cache return path and the decoder; optional macro
//             IC_ID_QUEUE_BYPASS_EN lets an empty queue forward straight to ID.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ic_id_inst_queue #(
   parameter int DEPTH  = 4,
   parameter int INST_W = 32,
   parameter int PC_W   = 32,
   parameter int EXC_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       br_e,
   input  logic                       hold,
   input  logic                       in_valid,
   input  logic [INST_W-1:0]          in_inst,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [EXC_W-1:0]           in_exc,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [INST_W-1:0]          out_inst,
   output logic [PC_W-1:0]            out_pc,
   output logic [EXC_W-1:0]           out_exc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = EXC_W + PC_W + INST_W;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [EW-1:0] out_q, out_d;

   logic [EW-1:0] w_in_entry;
   logic          w_ready;
   logic          w_bypass;
   logic          w_pop;
   logic          w_wr;

   assign w_in_entry = {in_exc, in_pc, in_inst};
   assign w_ready    = (count_q != C_FULL);

`ifdef IC_ID_QUEUE_BYPASS_EN
   assign w_bypass = in_valid && (count_q == '0) && !hold;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_pop = !hold && (count_q != '0);
   // Bypassed entries go straight to the output register and never touch storage.
   assign w_wr  = in_valid && w_ready && !w_bypass && !flush && !br_e;

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      if (flush) begin
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
         out_d       = '0;
      end else if (br_e) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         // A held output register is the delay slot and survives the kill.
         if (!hold) begin
            out_valid_d = 1'b0;
            out_d       = '0;
         end
      end else begin
         if (w_bypass) begin
            out_valid_d = 1'b1;
            out_d       = w_in_entry;
         end else if (!hold) begin
            if (w_pop) begin
               out_valid_d = 1'b1;
               out_d       = mem_q[head_q];
               head_d      = head_q + PW'(1);
            end else begin
               out_valid_d = 1'b0;
               out_d       = '0;
            end
         end
         if (w_wr) begin
            tail_d = tail_q + PW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         mem_q[tail_q] <= w_in_entry;
      end
   end

   assign in_ready  = w_ready;
   assign out_valid = out_valid_q;
   assign out_inst  = out_q[INST_W-1:0];
   assign out_pc    = out_q[INST_W +: PC_W];
   assign out_exc   = out_q[EW-1 -: EXC_W];
   assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_ic_id_inst_queue.sv
// ============================================================================
//  Module   : tb_ic_id_inst_queue
//  Purpose  : Directed table-driven bench for ic_id_inst_queue (DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ic_id_inst_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IC_ID_QUEUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          flush, br_e, hold, in_valid;
   logic [31:0]   in_inst, in_pc, in_exc;
   logic          in_ready, out_valid;
   logic [31:0]   out_inst, out_pc, out_exc;
   logic [CW-1:0] count;

   int nchk  = 0;
   int npass = 0;

   always #5 clk = ~clk;

   ic_id_inst_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32), .EXC_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .br_e(br_e), .hold(hold),
      .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_exc(in_exc),
      .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
      .out_pc(out_pc), .out_exc(out_exc), .count(count)
   );

   typedef struct {
      logic          fl, br, hd, iv;
      logic [31:0]   pc;
      logic          ev;
      logic [31:0]   epc;
      logic [CW-1:0] ecnt;
      logic          erdy;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] exc_of(input logic [31:0] pc);
      return (pc == 32'h8 || pc == 32'h404 || pc == 32'hBFC0_0004) ? 32'h0001_0000 : 32'h0;
   endfunction

   task automatic drive(input logic fl, input logic br, input logic hd,
                        input logic iv, input logic [31:0] pc);
      flush    = fl;
      br_e     = br;
      hold     = hd;
      in_valid = iv;
      in_pc    = pc;
      in_inst  = inst_of(pc);
      in_exc   = exc_of(pc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         npass++;
   endtask

   task automatic check_out(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [CW-1:0] ecnt, input logic erdy);
      check({tag, ".valid"}, 64'(out_valid), 64'(ev));
      check({tag, ".pc"},    64'(out_pc),    64'(ev ? epc : 32'h0));
      check({tag, ".inst"},  64'(out_inst),  64'(ev ? inst_of(epc) : 32'h0));
      check({tag, ".exc"},   64'(out_exc),   64'(ev ? exc_of(epc) : 32'h0));
      check({tag, ".count"}, 64'(count),     64'(ecnt));
      check({tag, ".ready"}, 64'(in_ready),  64'(erdy));
   endtask

   task automatic add(input logic fl, input logic br, input logic hd, input logic iv,
                      input logic [31:0] pc, input logic ev, input logic [31:0] epc,
                      input int ecnt, input logic erdy);
      vec_t v;
      v.fl = fl; v.br = br; v.hd = hd; v.iv = iv; v.pc = pc;
      v.ev = ev; v.epc = epc; v.ecnt = CW'(ecnt); v.erdy = erdy;
      vq.push_back(v);
   endtask

   initial begin
      logic [31:0] base;
      int          idx;
      base = 32'hBFC0_0000;

      // Reset state, including output garbage-free after release
      rst = 1'b0;
      drive(0, 0, 0, 1, 32'h44);
      step();
      step();
      check_out("rst_low", 0, 0, 0, 1);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      step();
      check_out("rst_rel", 0, 0, 0, 1);

      //   fl br hd iv pc          ev epc          cnt rdy
      add(0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 1);
      // fill under hold, 5th push dropped
      add(0, 0, 1, 1, 32'h0,      0, 32'h0,       1, 1);
      add(0, 0, 1, 1, 32'h4,      0, 32'h0,       2, 1);
      add(0, 0, 1, 1, 32'h8,      0, 32'h0,       3, 1);
      add(0, 0, 1, 1, 32'hC,      0, 32'h0,       4, 0);
      add(0, 0, 1, 1, 32'h10,     0, 32'h0,       4, 0);
      add(0, 0, 0, 0, 32'h0,      1, 32'h0,       3, 1);
      add(0, 0, 0, 0, 32'h0,      1, 32'h4,       2, 1);
      add(0, 0, 0, 0, 32'h0,      1, 32'h8,       1, 1);
      add(0, 0, 0, 0, 32'h0,      1, 32'hC,       0, 1);
      add(0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 1);
      // branch kill keeps delay slot under hold
      add(0, 0, 1, 1, 32'h100,    0, 32'h0,       1, 1);
      add(0, 0, 0, 0, 32'h0,      1, 32'h100,     0, 1);
      add(0, 0, 1, 1, 32'h104,    1, 32'h100,     1, 1);
      add(0, 0, 1, 1, 32'h108,    1, 32'h100,     2, 1);
      add(0, 1, 1, 1, 32'h10C,    1, 32'h100,     0, 1);
      add(0, 1, 0, 1, 32'h200,    0, 32'h0,       0, 1);
      add(0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 1);
      // flush with queued entries and a simultaneous push
      add(0, 0, 1, 1, 32'h2F0,    0, 32'h0,       1, 1);
      add(0, 0, 0, 0, 32'h0,      1, 32'h2F0,     0, 1);
      add(0, 0, 1, 1, 32'h300,    1, 32'h2F0,     1, 1);
      add(0, 0, 1, 1, 32'h304,    1, 32'h2F0,     2, 1);
      add(0, 0, 1, 1, 32'h308,    1, 32'h2F0,     3, 1);
      add(1, 0, 1, 1, 32'h30C,    0, 32'h0,       0, 1);
      add(0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 1);
      // full: pop with push refused, then push+pop holds count
      add(0, 0, 1, 1, 32'h400,    0, 32'h0,       1, 1);
      add(0, 0, 1, 1, 32'h404,    0, 32'h0,       2, 1);
      add(0, 0, 1, 1, 32'h408,    0, 32'h0,       3, 1);
      add(0, 0, 1, 1, 32'h40C,    0, 32'h0,       4, 0);
      add(0, 0, 0, 1, 32'h410,    1, 32'h400,     3, 1);
      add(0, 0, 0, 1, 32'h410,    1, 32'h404,     3, 1);
      add(0, 0, 0, 0, 32'h0,      1, 32'h408,     2, 1);
      add(0, 0, 0, 0, 32'h0,      1, 32'h40C,     1, 1);
      add(0, 0, 0, 0, 32'h0,      1, 32'h410,     0, 1);
      add(0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 1);

      foreach (vq[i]) begin
         drive(vq[i].fl, vq[i].br, vq[i].hd, vq[i].iv, vq[i].pc);
         step();
         check_out($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].ecnt, vq[i].erdy);
      end

      // Streaming latency and gap-free throughput
      for (int k = 0; k < 6; k++) begin
         if (k < 3) drive(0, 0, 0, 1, base + 32'(4 * k));
         else       drive(0, 0, 0, 0, 0);
         step();
         idx = k - (LAT - 1);
         check_out($sformatf("stream%0d", k), (idx >= 0 && idx <= 2),
                   base + 32'(4 * idx),
                   (LAT == 1) ? CW'(0) : ((k <= 2) ? CW'(1) : CW'(0)), 1);
      end

      // Reset mid-burst wins over hold and in_valid
      drive(0, 0, 1, 1, 32'h500);
      step();
      drive(0, 0, 1, 1, 32'h504);
      step();
      check("midrst.pre_count", 64'(count), 64'd2);
      rst = 1'b0;
      drive(0, 0, 1, 1, 32'h508);
      step();
      check_out("midrst", 0, 0, 0, 1);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      step();
      check_out("midrst_after", 0, 0, 0, 1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ic_id_inst_queue.md
# ic_id_inst_queue

Parametrised instruction queue and ID-stage pipeline register between the instruction-cache return path and the decoder. It accepts fetched {excepttype, pc, inst} entries, buffers up to DEPTH of them while decode is held, and presents one entry per cycle to the decoder. Branch kill and pipeline flush discard wrong-path entries, and cache returns are never lost during a stall.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `INST_W`, 32: instruction width.
- `PC_W`, 32: PC width.
- `EXC_W`, 32: exception-type vector width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset. `rst==0` at a rising edge resets the block.
- `flush` in 1: exception/ERET flush; discard everything.
- `br_e` in 1: branch taken, resolved in EX; discard wrong-path entries.
- `hold` in 1: decode stalled; the output register must not advance.
- `in_valid` in 1: cache returns an entry this cycle.
- `in_inst` in INST_W: fetched instruction.
- `in_pc` in PC_W: fetch PC.
- `in_exc` in EXC_W: exception bits attached at fetch.
- `in_ready` out 1: queue can accept an entry this cycle.
- `out_valid` out 1: output register holds a real instruction.
- `out_inst` out INST_W: instruction to the decoder; 0 when `out_valid==0`.
- `out_pc` out PC_W: PC to the decoder; 0 when invalid.
- `out_exc` out EXC_W: exception vector to the decoder; 0 when invalid.
- `count` out $clog2(DEPTH)+1: entries currently queued, excluding the output register.

## Operation
- Storage is a circular buffer of DEPTH entries plus one output register.
- Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately, range 0..DEPTH.
- `in_ready = (count != DEPTH)`. This is combinational from `count` only: no push is accepted when full, even if a pop occurs in the same cycle.
- Push: `in_valid & in_ready` writes the entry at tail; tail and count advance.
- Advance: when `hold==0`, the output register loads the head entry (pop) if `count>0`. Otherwise it loads a bubble (valid=0, all fields 0).
- When `hold==1`, the output register and head are unchanged.
- Push and pop in the same cycle leave `count` unchanged.
- Event priority, highest first:
  1. Reset: output register bubble, pointers 0, `count` 0.
  2. `flush`: same effect as reset. `in_valid` that cycle is dropped.
  3. `br_e`:
     - Queue emptied; same-cycle `in_valid` dropped.
     - If `hold==1`, the output register (the delay slot) is kept.
     - If `hold==0`, the output register loads a bubble.
  4. Normal push/advance.
- Entries are never reordered. The exception vector travels with its instruction unchanged.
- Bubbles presented to the decoder are all-zero words (decode as NOP/SLL).

## Timing
- Reset values: `out_valid=0`, `out_inst=0`, `out_pc=0`, `out_exc=0`, `count=0`, `in_ready=1`.
- Latency from accepted input at edge N to `out_valid`, with no `hold`:
  - 1 cycle with bypass (see Configuration).
  - 2 cycles without bypass.
- Throughput: one entry per cycle in steady state.
- Full-boundary example, DEPTH=4:
  - With `hold=1` and 5 back-to-back pushes, pushes 1–4 are accepted; `in_ready` falls after the 4th.
  - The 5th must be held by the source.
- `flush` or `br_e` takes effect at the same edge it is sampled. `in_ready` is 1 the following cycle.
- Reset asserted mid-burst: all state is cleared at that edge regardless of `hold`/`in_valid`.

## Configuration
- `IC_ID_QUEUE_BYPASS_EN` defined:
  - Condition: `in_valid` with `count==0`, `hold==0`, no `flush`/`br_e`.
  - Effect: the entry loads the output register directly at that edge. The queue is not written and `count` stays 0.
- Undefined: every entry is written into the queue first and popped on a later advance. Latency is +1 cycle; the bubble-free steady state is preserved once the queue is non-empty.

## Test plan
- Reset, then `rst=1` with no input: `out_valid=0`, all outputs 0, `in_ready=1`, `count=0`.
- Stream pc 0xBFC00000, +4, +8 with `hold=0`:
  - Bypass on: out pc 0xBFC00000 one cycle after the first push.
  - Bypass off: two cycles after. Consecutive cycles follow with no gaps.
- `hold=1` and 5 pushes, DEPTH=4: `count=4`, `in_ready=0`, 5th dropped.
- Release `hold`: out pcs 0x0, 0x4, 0x8, 0xC appear in order, then a bubble.
- `hold=1` with output pc 0x100 and 2 queued; assert `br_e` with `in_valid`: `count=0`, output still pc 0x100. Then `br_e` with `hold=0`: output becomes bubble.
- `flush` with 3 queued and a simultaneous push: next cycle `out_valid=0`, `count=0`, `in_ready=1`.
- Push entry with `in_exc=0x00010000`: the matching `out_exc` equals 0x00010000 on the same cycle its pc appears.
